// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS decode constants.
// Provides opcode/funct encodings and the link register index used by the
// hazard logic (load_use_interlock) and its decoder (instr_reguse). No ports.
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001;

    // Link register written by jal
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/instr_reguse.sv
// instr_reguse: purely combinational register-usage decoder.
// Ports:
//   instr_i      - 32-bit MIPS instruction
//   rs_used_o    - instruction reads the rs field
//   rt_used_o    - instruction reads the rt field
//   dst_o        - destination register index (meaningful when dst_valid_o)
//   dst_valid_o  - instruction writes a register (dst_o may still be r0)
//   is_load_o    - destination is written by a load (long latency)
module instr_reguse
    import mips_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        rs_used_o,
    output logic        rt_used_o,
    output logic [4:0]  dst_o,
    output logic        dst_valid_o,
    output logic        is_load_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];
    assign rt    = instr_i[20:16];
    assign rd    = instr_i[15:11];

    // Shift amount never names a register.
    assign unused_shamt = ^instr_i[10:6];

    // Default is the generic I-type: reads rs, writes rt.
    always_comb begin
        rs_used_o   = 1'b1;
        rt_used_o   = 1'b0;
        dst_o       = rt;
        dst_valid_o = 1'b1;
        is_load_o   = 1'b0;
        case (op)
            OP_RTYPE: begin
                rt_used_o = 1'b1;
                dst_o     = rd;
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        rs_used_o = 1'b0;
                    end
                    FN_JR: begin
                        rt_used_o   = 1'b0;
                        dst_valid_o = 1'b0;
                    end
                    FN_JALR: begin
                        rt_used_o = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                rs_used_o   = 1'b0;
                dst_valid_o = 1'b0;
            end
            OP_JAL: begin
                rs_used_o = 1'b0;
                dst_o     = REG_RA;
            end
            OP_LW, OP_LB, OP_LBU: begin
                is_load_o = 1'b1;
            end
            OP_SW, OP_SB, OP_BEQ, OP_BNE: begin
                rt_used_o   = 1'b1;
                dst_valid_o = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_use_interlock.sv
// load_use_interlock: ID-stage stall generator for producers that cannot
// forward in time. A per-register countdown scoreboard records how many more
// cycles each pending result is unforwardable; the ID instruction stalls
// (with an ID/EX bubble) while any source it reads has a nonzero count.
// Ports:
//   clk, rst      - clock (rising edge), synchronous active-high reset
//   id_valid      - IF/ID holds a live instruction
//   id_instr      - instruction in IF/ID
//   freeze        - pipeline-wide hold: counts frozen, nothing issues
//   flush         - IF/ID instruction killed: no issue, no stall
//   stall         - hold PC and IF/ID
//   ex_bubble     - load NOP into ID/EX (identical to stall)
//   stall_cycles  - saturating count of stalled cycles
// Parameters: LOAD_LAT / ALU_LAT are the unforwardable windows; CW must be
// wide enough that 2^CW-1 >= max(LOAD_LAT, ALU_LAT).
module load_use_interlock
    import mips_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned CW       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic        freeze,
    input  logic        flush,
    output logic        stall,
    output logic        ex_bubble,
    output logic [31:0] stall_cycles
);

    localparam logic [CW-1:0] LoadCnt = CW'(LOAD_LAT);
    localparam logic [CW-1:0] AluCnt  = CW'(ALU_LAT);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    // Decoded register usage of the ID instruction
    logic       rs_used;
    logic       rt_used;
    logic [4:0] dst;
    logic       dst_valid;
    logic       is_load;
    logic [4:0] rs;
    logic [4:0] rt;

    instr_reguse u_reguse (
        .instr_i     (id_instr),
        .rs_used_o   (rs_used),
        .rt_used_o   (rt_used),
        .dst_o       (dst),
        .dst_valid_o (dst_valid),
        .is_load_o   (is_load)
    );

    assign rs = id_instr[25:21];
    assign rt = id_instr[20:16];

    // Scoreboard; entry 0 is held at zero so r0 never looks busy.
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic [31:0]   stall_cycles_q;
    logic [31:0]   stall_cycles_d;

    logic          rs_busy;
    logic          rt_busy;
    logic          issue;
    logic          dst_track;
    logic [CW-1:0] issue_cnt;

    always_comb begin
        rs_busy = rs_used && (rs != 5'd0) && (cnt_q[rs] != '0);
        rt_busy = rt_used && (rt != 5'd0) && (cnt_q[rt] != '0);
    end

    assign stall     = id_valid && !flush && (rs_busy || rt_busy);
    assign ex_bubble = stall;

    assign issue     = id_valid && !flush && !stall && !freeze;
    assign dst_track = dst_valid && (dst != 5'd0);
    assign issue_cnt = is_load ? LoadCnt : AluCnt;

    // Decrement unless frozen; a new issue to the same register wins.
    // Sources were checked against the old count, so an instruction that
    // reads and writes the same register sees its producer, not itself.
    always_comb begin
        cnt_d[0] = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!freeze && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntOne;
            end
            if (issue && dst_track && (dst == 5'(i))) begin
                cnt_d[i] = issue_cnt;
            end
        end
    end

    // Frozen stall cycles are counted too.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_use_interlock.sv
module tb_load_use_interlock;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        freeze;
    logic        flush;
    logic        stall;
    logic        ex_bubble;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    load_use_interlock dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .freeze       (freeze),
        .flush        (flush),
        .stall        (stall),
        .ex_bubble    (ex_bubble),
        .stall_cycles (stall_cycles)
    );

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] ins;
        logic        fr;
        logic        fl;
        int          exp_stall;
    } vec_t;
    vec_t vecs[$];

    // Reference model: each register has the tick (count of unfrozen edges)
    // at which its pending value becomes forwardable.
    longint ready [32];
    longint tick;
    longint msc;
    bit     model_ok = 0;

    function automatic logic [31:0] rtype(int rs, int rt, int rd, int sh, int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output bit rs_rd,
                                       output bit rt_rd, output int dst, output int lat);
        int op;
        int fn;
        op    = int'(ins[31:26]);
        fn    = int'(ins[5:0]);
        rs_rd = 1;
        rt_rd = 0;
        dst   = int'(ins[20:16]);
        lat   = 0;
        if (op == 0) begin
            rs_rd = !(fn == 0 || fn == 2 || fn == 3);
            rt_rd = !(fn == 8 || fn == 9);
            dst   = (fn == 8) ? -1 : int'(ins[15:11]);
        end else if (op == 2) begin
            rs_rd = 0;
            dst   = -1;
        end else if (op == 3) begin
            rs_rd = 0;
            dst   = 31;
        end else if (op == 'h23 || op == 'h20 || op == 'h24) begin
            lat = 1;
        end else if (op == 'h2b || op == 'h28 || op == 4 || op == 5) begin
            rt_rd = 1;
            dst   = -1;
        end
    endfunction

    function automatic bit busy(int r);
        return (r != 0) && (ready[r] > tick);
    endfunction

    function automatic bit model_stall(logic v, logic [31:0] ins, logic fl);
        bit rs_rd, rt_rd;
        int dst, lat;
        ref_decode(ins, rs_rd, rt_rd, dst, lat);
        return v && !fl && ((rs_rd && busy(int'(ins[25:21]))) ||
                            (rt_rd && busy(int'(ins[20:16]))));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare 1ns later, advance model at posedge.
    task automatic cycle(input logic r, input logic v, input logic [31:0] ins,
                         input logic fr, input logic fl, input int exp_st, input string nm);
        bit ms;
        bit rs_rd, rt_rd;
        int dst, lat;
        @(negedge clk);
        rst      = r;
        id_valid = v;
        id_instr = ins;
        freeze   = fr;
        flush    = fl;
        #1;
        ms = model_stall(v, ins, fl);
        if (model_ok) begin
            chk({nm, ".stall"}, 32'(stall), 32'(ms));
            chk({nm, ".bubble"}, 32'(ex_bubble), 32'(ms));
            chk({nm, ".cycles"}, stall_cycles, 32'(msc));
        end
        if (exp_st >= 0) chk({nm, ".tbl"}, 32'(stall), 32'(exp_st));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) ready[i] = 0;
            tick     = 0;
            msc      = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (ms && msc < 64'hFFFF_FFFF) msc++;
            if (!fr) tick++;
            ref_decode(ins, rs_rd, rt_rd, dst, lat);
            if (v && !fl && !ms && !fr && dst > 0) ready[dst] = tick + lat;
        end
    endtask

    function automatic void add(logic r, logic v, logic [31:0] ins, logic fr, logic fl, int e);
        vecs.push_back('{r, v, ins, fr, fl, e});
    endfunction

    initial begin
        logic [31:0] lw8, add_dep, sll_dep, sll_ind, lw0, add_r0, lw12, add12;
        logic [31:0] lw8_8, lb5, beq5, sw8, jal_i, jr31;
        int ops [16];
        int fns [8];

        rst = 1'b1; id_valid = 1'b0; id_instr = '0; freeze = 1'b0; flush = 1'b0;

        lw8     = itype('h23, 0, 8, 0);
        add_dep = rtype(8, 10, 9, 0, 'h20);
        sll_dep = rtype(0, 8, 9, 2, 0);
        sll_ind = rtype(8, 3, 9, 2, 0);
        lw0     = itype('h23, 0, 0, 0);
        add_r0  = rtype(0, 0, 1, 0, 'h20);
        lw12    = itype('h23, 0, 12, 0);
        add12   = rtype(12, 0, 13, 0, 'h20);
        lw8_8   = itype('h23, 8, 8, 4);
        lb5     = itype('h20, 0, 5, 0);
        beq5    = itype('h04, 5, 0, 3);
        sw8     = itype('h2b, 1, 8, 0);
        jal_i   = {6'h03, 26'h10};
        jr31    = rtype(31, 0, 0, 0, 8);

        add(1, 0, 0, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // basic load-use
        add(0, 1, add_dep, 0, 0, 1);
        add(0, 1, add_dep, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // bubble hides latency
        add(0, 0, 0, 0, 0, 0);
        add(0, 1, add_dep, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // sll reads rt only
        add(0, 1, sll_dep, 0, 0, 1);
        add(0, 1, sll_dep, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);
        add(0, 1, sll_ind, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // freeze stretches stall
        add(0, 1, add_dep, 1, 0, 1);
        add(0, 1, add_dep, 1, 0, 1);
        add(0, 1, add_dep, 1, 0, 1);
        add(0, 1, add_dep, 0, 0, 1);
        add(0, 1, add_dep, 0, 0, 0);
        add(0, 1, lw0, 0, 0, 0);      // r0 never tracked
        add(0, 1, add_r0, 0, 0, 0);
        add(0, 1, lw12, 0, 1, 0);     // flushed load does not issue
        add(0, 1, add12, 0, 0, 0);
        add(0, 1, lw12, 1, 0, 0);     // frozen load does not issue
        add(0, 1, add12, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);
        add(0, 1, add_dep, 0, 1, 0);  // flush suppresses stall
        add(0, 1, lw8, 0, 0, 0);      // src == dst
        add(0, 1, lw8_8, 0, 0, 1);
        add(0, 1, lw8_8, 0, 0, 0);
        add(0, 1, add_dep, 0, 0, 1);
        add(0, 1, add_dep, 0, 0, 0);
        add(0, 1, lb5, 0, 0, 0);      // branch reads rs
        add(0, 1, beq5, 0, 0, 1);
        add(0, 1, beq5, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // store reads rt
        add(0, 1, sw8, 0, 0, 1);
        add(0, 1, sw8, 0, 0, 0);
        add(0, 1, jal_i, 0, 0, 0);    // ALU-latency producer
        add(0, 1, jr31, 0, 0, 0);
        add(0, 1, lw8, 0, 0, 0);      // reset mid-stall
        add(1, 1, add_dep, 0, 0, 1);
        add(0, 1, add_dep, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].v, vecs[i].ins, vecs[i].fr, vecs[i].fl,
                  vecs[i].exp_stall, $sformatf("tbl[%0d]", i));
        end
        chk("post_reset.cycles", stall_cycles, 32'd0);

        // Randomized traffic over a small register window
        ops = '{0, 0, 0, 0, 'h23, 'h23, 'h20, 'h24, 'h2b, 'h28, 4, 5, 2, 3, 8, 'h0d};
        fns = '{'h20, 'h22, 0, 2, 3, 8, 9, 'h2a};
        for (int n = 0; n < 1500; n++) begin
            int op, rs_f, rt_f, rd_f;
            logic [31:0] ins;
            op   = ops[$urandom_range(0, 15)];
            rs_f = $urandom_range(0, 7);
            rt_f = $urandom_range(0, 7);
            rd_f = $urandom_range(0, 7);
            if (op == 0) ins = rtype(rs_f, rt_f, rd_f, $urandom_range(0, 31),
                                     fns[$urandom_range(0, 7)]);
            else         ins = itype(op, rs_f, rt_f, $urandom_range(0, 65535));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), ins,
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0), -1,
                  $sformatf("rnd[%0d]", n));
        end

        // Saturation: preload the counter near its top, then hold a stall.
        cycle(1, 0, 0, 0, 0, 0, "sat.rst");
        cycle(0, 1, lw8, 0, 0, 0, "sat.lw");
        #2;
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles_q;
        msc = 64'hFFFF_FFFD;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, add_dep, 1, 0, 1, $sformatf("sat.frz[%0d]", k));
        end
        cycle(0, 1, add_dep, 0, 0, 1, "sat.last");
        cycle(0, 1, add_dep, 0, 0, 0, "sat.issue");
        chk("sat.final", stall_cycles, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
